sayeh_mem_arbiter: RTL and testbench
====================================

SAYEH_MEM_ARBITER -- requirements
Module: sayeh_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, MemDataready wait limit in cycles (1..255), used only when MEM_ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 ExternalReset  input  1  synchronous, active-high reset.
REQ-004 cpu_ReadMem  input  1  CPU read request.
REQ-005 cpu_WriteMem  input  1  CPU write request.
REQ-006 cpu_Addressbus  input  16  CPU address.
REQ-007 cpu_Databus_out  input  16  CPU write data.
REQ-008 cpu_Dataready  output  1  one-cycle CPU completion pulse.
REQ-009 cpu_Databus_in  output  16  CPU read data.
REQ-010 dma_rd  input  1  DMA read request.
REQ-011 dma_wr  input  1  DMA write request.
REQ-012 dma_addr  input  16  DMA address.
REQ-013 dma_wdata  input  16  DMA write data.
REQ-014 dma_ack  output  1  one-cycle DMA completion pulse.
REQ-015 dma_rdata  output  16  DMA read data.
REQ-016 ReadMem  output  1  memory read strobe.
REQ-017 WriteMem  output  1  memory write strobe.
REQ-018 Addressbus  output  16  memory address.
REQ-019 Databus_out  output  16  memory write data.
REQ-020 Databus_in  input  16  memory read data.
REQ-021 MemDataready  input  1  memory completion.
REQ-022 grant_dma  output  1  0 = CPU owns bus, 1 = DMA owns bus (valid in transfer states).
REQ-023 timeout_err  output  1  one-cycle pulse alongside an ack that ended by timeout.

Function
REQ-024 FSM states SHALL be IDLE, CPU_XFER, DMA_XFER; all outputs SHALL be registered.
REQ-025 In IDLE, a pending request (rd|wr) SHALL move the FSM to CPU_XFER or DMA_XFER on the next edge; the memory strobes SHALL assert in that first transfer cycle.
REQ-026 If only one requester is pending, that requester SHALL be granted.
REQ-027 If both are pending, the requester not served last SHALL be granted; the last-served flag SHALL reset to DMA, so the CPU wins the first tie.
REQ-028 In a transfer state, Addressbus and Databus_out SHALL carry the granted requester's inputs, sampled at grant and held constant until completion.
REQ-029 Strobe selection: ReadMem = rd; WriteMem = wr && !rd; rd and wr both high SHALL be executed as a read.
REQ-030 When MemDataready is 1 in a transfer state: strobes deassert next cycle, Databus_in is captured into the granted side's read-data register (unchanged on writes), the granted side's ack pulses for exactly one cycle, and the FSM returns to IDLE.
REQ-031 Requesters SHALL hold their request until ack and drop it in the ack cycle.
REQ-032 A request still high in the ack cycle SHALL NOT be re-granted until the cycle after the ack.
REQ-033 Minimum spacing between back-to-back transfers SHALL be one IDLE cycle.
REQ-034 MemDataready in IDLE SHALL be ignored.
REQ-035 Request changes during a transfer SHALL NOT affect the transfer in progress.
REQ-036 The non-granted ack SHALL remain 0.

Reset
REQ-037 ExternalReset, sampled on clk, SHALL force: state IDLE, all strobes/acks/timeout_err 0, Addressbus/Databus_out/cpu_Databus_in/dma_rdata 16'h0000, grant_dma 0, last-served = DMA.
REQ-038 Reset mid-transfer SHALL abort the transfer with no ack.
REQ-039 Reset SHALL take priority over MemDataready in the same cycle.

Configuration
REQ-040 Macro MEM_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to a transfer state and increment each transfer cycle without MemDataready.
REQ-041 With MEM_ARB_TIMEOUT_EN, when the count reaches TIMEOUT_CYCLES, the block SHALL complete as in REQ-030 with read data 16'hFFFF and timeout_err = 1.
REQ-042 MemDataready arriving in the same cycle the count reaches TIMEOUT_CYCLES SHALL win: normal completion, no error.
REQ-043 Macro MEM_ARB_TIMEOUT_EN undefined: the block SHALL wait indefinitely for MemDataready, have no counter, and tie timeout_err to 0.

Verification
REQ-044 CPU read of 16'h0040 alone, MemDataready 3 cycles after ReadMem, Databus_in = 16'hBEEF -> ReadMem high 3 cycles, cpu_Dataready one pulse, cpu_Databus_in = 16'hBEEF.
REQ-045 CPU and DMA request in the same cycle twice in a row -> order CPU, DMA, CPU, DMA; grant_dma = 0,1,0,1.
REQ-046 DMA write to 16'h1234 of 16'h00A5 while CPU idle -> WriteMem = 1, Addressbus = 16'h1234, Databus_out = 16'h00A5, dma_ack one pulse, dma_rdata unchanged.
REQ-047 Reset asserted in the 2nd cycle of a CPU read -> next cycle all outputs at reset values, no cpu_Dataready, first subsequent tie granted to CPU.
REQ-048 With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 4, MemDataready held 0 -> after 4 cycles ack plus timeout_err pulse, read data 16'hFFFF; without the macro -> ReadMem stays high.
REQ-049 cpu_ReadMem and cpu_WriteMem both 1 -> ReadMem = 1, WriteMem = 0.

Source files
------------

// File: rtl/sayeh_mem_arbiter_if.sv
// sayeh_mem_arbiter_if
//   Bundles the CPU requester, DMA requester and memory-side signals of the
//   SAYEH memory arbiter.
//   modport slave  : the arbiter's view (requests and memory response in,
//                    strobes, address/data, acks and read data out).
//   modport master : the environment's view (CPU, DMA and memory models).
interface sayeh_mem_arbiter_if;
    // CPU side
    logic        cpu_ReadMem;
    logic        cpu_WriteMem;
    logic [15:0] cpu_Addressbus;
    logic [15:0] cpu_Databus_out;
    logic        cpu_Dataready;
    logic [15:0] cpu_Databus_in;
    // DMA side
    logic        dma_rd;
    logic        dma_wr;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_ack;
    logic [15:0] dma_rdata;
    // Memory side
    logic        ReadMem;
    logic        WriteMem;
    logic [15:0] Addressbus;
    logic [15:0] Databus_out;
    logic [15:0] Databus_in;
    logic        MemDataready;
    // Status
    logic        grant_dma;
    logic        timeout_err;

    modport slave (
        input  cpu_ReadMem, cpu_WriteMem, cpu_Addressbus, cpu_Databus_out,
        input  dma_rd, dma_wr, dma_addr, dma_wdata,
        input  Databus_in, MemDataready,
        output cpu_Dataready, cpu_Databus_in, dma_ack, dma_rdata,
        output ReadMem, WriteMem, Addressbus, Databus_out,
        output grant_dma, timeout_err
    );

    modport master (
        output cpu_ReadMem, cpu_WriteMem, cpu_Addressbus, cpu_Databus_out,
        output dma_rd, dma_wr, dma_addr, dma_wdata,
        output Databus_in, MemDataready,
        input  cpu_Dataready, cpu_Databus_in, dma_ack, dma_rdata,
        input  ReadMem, WriteMem, Addressbus, Databus_out,
        input  grant_dma, timeout_err
    );
endinterface

// File: rtl/sayeh_mem_arbiter.sv
// sayeh_mem_arbiter
//   Two-requester (CPU, DMA) arbiter in front of a single memory port.
//   One transfer at a time; ties alternate, CPU wins the first one.
//   Ports:
//     clk           rising-edge clock
//     ExternalReset synchronous, active-high reset
//     bus           sayeh_mem_arbiter_if.slave (requests, memory port, acks)
//   Parameter:
//     TIMEOUT_CYCLES  MemDataready wait limit (1..255)
//   Optional feature:
//     MEM_ARB_TIMEOUT_EN  when defined, a transfer that sees no MemDataready
//                         for TIMEOUT_CYCLES cycles completes with read data
//                         16'hFFFF and a timeout_err pulse. When undefined the
//                         arbiter waits forever and timeout_err stays 0.
module sayeh_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               ExternalReset,
    sayeh_mem_arbiter_if.slave bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, CPU_XFER, DMA_XFER} state_t;

    state_t state;
    logic   lastDma;      // last served requester was DMA
    logic   cpuReq;
    logic   dmaReq;
    logic   pickDma;
    logic   ackCycle;
    logic   toHit;

    assign cpuReq  = bus.cpu_ReadMem | bus.cpu_WriteMem;
    assign dmaReq  = bus.dma_rd | bus.dma_wr;
    // DMA wins if alone, or on a tie when the CPU was served last.
    assign pickDma = dmaReq & (~cpuReq | ~lastDma);
    // Requests are still allowed to be high while the ack is out; don't
    // re-grant until the requester has had its ack cycle to drop them.
    assign ackCycle = bus.cpu_Dataready | bus.dma_ack;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] toCnt;
    // Fires in the cycle whose (missing) MemDataready would bring the
    // count to TIMEOUT_CYCLES; a MemDataready in that same cycle wins.
    assign toHit = (toCnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign toHit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (ExternalReset) begin
            state              <= IDLE;
            lastDma            <= 1'b1;
            bus.ReadMem        <= 1'b0;
            bus.WriteMem       <= 1'b0;
            bus.Addressbus     <= 16'h0000;
            bus.Databus_out    <= 16'h0000;
            bus.cpu_Dataready  <= 1'b0;
            bus.cpu_Databus_in <= 16'h0000;
            bus.dma_ack        <= 1'b0;
            bus.dma_rdata      <= 16'h0000;
            bus.grant_dma      <= 1'b0;
            bus.timeout_err    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            toCnt              <= 8'd0;
`endif
        end else begin
            bus.cpu_Dataready <= 1'b0;
            bus.dma_ack       <= 1'b0;
            bus.timeout_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if ((cpuReq | dmaReq) && !ackCycle) begin
                        bus.grant_dma <= pickDma;
                        lastDma       <= pickDma;
`ifdef MEM_ARB_TIMEOUT_EN
                        toCnt         <= 8'd0;
`endif
                        if (pickDma) begin
                            state           <= DMA_XFER;
                            bus.Addressbus  <= bus.dma_addr;
                            bus.Databus_out <= bus.dma_wdata;
                            bus.ReadMem     <= bus.dma_rd;
                            bus.WriteMem    <= bus.dma_wr & ~bus.dma_rd;
                        end else begin
                            state           <= CPU_XFER;
                            bus.Addressbus  <= bus.cpu_Addressbus;
                            bus.Databus_out <= bus.cpu_Databus_out;
                            bus.ReadMem     <= bus.cpu_ReadMem;
                            bus.WriteMem    <= bus.cpu_WriteMem & ~bus.cpu_ReadMem;
                        end
                    end
                end
                CPU_XFER, DMA_XFER: begin
                    if (bus.MemDataready || toHit) begin
                        state           <= IDLE;
                        bus.ReadMem     <= 1'b0;
                        bus.WriteMem    <= 1'b0;
                        bus.timeout_err <= ~bus.MemDataready;
                        if (state == CPU_XFER) begin
                            bus.cpu_Dataready <= 1'b1;
                            if (bus.ReadMem)
                                bus.cpu_Databus_in <= bus.MemDataready ? bus.Databus_in : 16'hFFFF;
                        end else begin
                            bus.dma_ack <= 1'b1;
                            if (bus.ReadMem)
                                bus.dma_rdata <= bus.MemDataready ? bus.Databus_in : 16'hFFFF;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else begin
                        toCnt <= toCnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sayeh_mem_arbiter.sv
// tb_sayeh_mem_arbiter
//   Directed bench for sayeh_mem_arbiter. Inputs change 1 time unit after
//   the rising edge; outputs are checked at that same point, i.e. they
//   reflect the state registered on the preceding edge.
module tb_sayeh_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sayeh_mem_arbiter_if bus ();

    sayeh_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .ExternalReset(rst),
        .bus          (bus)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chkQuiet(input string tag);
        chk({tag, ".ReadMem"},  16'(bus.ReadMem),       16'h0);
        chk({tag, ".WriteMem"}, 16'(bus.WriteMem),      16'h0);
        chk({tag, ".cpuRdy"},   16'(bus.cpu_Dataready), 16'h0);
        chk({tag, ".dmaAck"},   16'(bus.dma_ack),       16'h0);
        chk({tag, ".toErr"},    16'(bus.timeout_err),   16'h0);
    endtask

    initial begin
        bus.cpu_ReadMem = 0; bus.cpu_WriteMem = 0;
        bus.cpu_Addressbus = 0; bus.cpu_Databus_out = 0;
        bus.dma_rd = 0; bus.dma_wr = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
        bus.Databus_in = 0; bus.MemDataready = 0;
        rst = 1;
        tick; tick;

        // reset state
        chkQuiet("rst");
        chk("rst.addr",  bus.Addressbus,     16'h0000);
        chk("rst.dout",  bus.Databus_out,    16'h0000);
        chk("rst.cpuRd", bus.cpu_Databus_in, 16'h0000);
        chk("rst.dmaRd", bus.dma_rdata,      16'h0000);
        chk("rst.grant", 16'(bus.grant_dma), 16'h0);
        rst = 0;
        tick;

        // MemDataready in IDLE is ignored
        bus.MemDataready = 1; bus.Databus_in = 16'h9999;
        tick;
        bus.MemDataready = 0;
        tick;
        chkQuiet("idleRdy");
        chk("idleRdy.cpuRd", bus.cpu_Databus_in, 16'h0000);

        // CPU read of 0x0040, MemDataready in 3rd strobe cycle
        bus.cpu_ReadMem = 1; bus.cpu_Addressbus = 16'h0040;
        tick;
        chk("cr.t0.rd",    16'(bus.ReadMem),   16'h1);
        chk("cr.t0.addr",  bus.Addressbus,     16'h0040);
        chk("cr.t0.grant", 16'(bus.grant_dma), 16'h0);
        bus.cpu_Addressbus = 16'h7777;   // must not disturb the transfer
        tick;
        chk("cr.t1.rd",   16'(bus.ReadMem), 16'h1);
        chk("cr.t1.addr", bus.Addressbus,   16'h0040);
        tick;
        chk("cr.t2.rd",  16'(bus.ReadMem),       16'h1);
        chk("cr.t2.rdy", 16'(bus.cpu_Dataready), 16'h0);
        bus.MemDataready = 1; bus.Databus_in = 16'hBEEF;
        tick;
        chk("cr.ack.rdy",  16'(bus.cpu_Dataready), 16'h1);
        chk("cr.ack.rd",   16'(bus.ReadMem),       16'h0);
        chk("cr.ack.data", bus.cpu_Databus_in,     16'hBEEF);
        chk("cr.ack.dma",  16'(bus.dma_ack),       16'h0);
        bus.cpu_ReadMem = 0; bus.MemDataready = 0;
        tick;
        chk("cr.after.rdy", 16'(bus.cpu_Dataready), 16'h0);

        // DMA write 0x00A5 -> 0x1234 with CPU idle
        bus.dma_wr = 1; bus.dma_addr = 16'h1234; bus.dma_wdata = 16'h00A5;
        tick;
        chk("dw.wr",    16'(bus.WriteMem),  16'h1);
        chk("dw.rd",    16'(bus.ReadMem),   16'h0);
        chk("dw.addr",  bus.Addressbus,     16'h1234);
        chk("dw.dout",  bus.Databus_out,    16'h00A5);
        chk("dw.grant", 16'(bus.grant_dma), 16'h1);
        bus.MemDataready = 1; bus.Databus_in = 16'h5555;
        tick;
        chk("dw.ack",   16'(bus.dma_ack),       16'h1);
        chk("dw.cpu",   16'(bus.cpu_Dataready), 16'h0);
        chk("dw.rdata", bus.dma_rdata,          16'h0000);
        chk("dw.wrOff", 16'(bus.WriteMem),      16'h0);
        bus.dma_wr = 0; bus.MemDataready = 0;
        tick;
        chk("dw.after", 16'(bus.dma_ack), 16'h0);

        // Ties: CPU, DMA, CPU, DMA
        bus.cpu_ReadMem = 1; bus.cpu_Addressbus = 16'h0100;
        bus.dma_rd = 1;      bus.dma_addr = 16'h0200;
        tick;
        chk("tie1.grant", 16'(bus.grant_dma), 16'h0);
        chk("tie1.addr",  bus.Addressbus,     16'h0100);
        bus.MemDataready = 1; bus.Databus_in = 16'h1111;
        tick;
        chk("tie1.ack", 16'(bus.cpu_Dataready), 16'h1);
        bus.cpu_ReadMem = 0; bus.MemDataready = 0;
        tick;
        chk("tie1.gap", 16'(bus.ReadMem), 16'h0);
        bus.cpu_ReadMem = 1; bus.cpu_Addressbus = 16'h0300;
        tick;
        chk("tie2.grant", 16'(bus.grant_dma), 16'h1);
        chk("tie2.addr",  bus.Addressbus,     16'h0200);
        bus.MemDataready = 1; bus.Databus_in = 16'h2222;
        tick;
        chk("tie2.ack",  16'(bus.dma_ack), 16'h1);
        chk("tie2.data", bus.dma_rdata,    16'h2222);
        chk("tie2.cpu",  bus.cpu_Databus_in, 16'h1111);
        bus.dma_rd = 0; bus.MemDataready = 0;
        tick;
        bus.dma_rd = 1; bus.dma_addr = 16'h0400;
        tick;
        chk("tie3.grant", 16'(bus.grant_dma), 16'h0);
        chk("tie3.addr",  bus.Addressbus,     16'h0300);
        bus.MemDataready = 1; bus.Databus_in = 16'h3333;
        tick;
        chk("tie3.data", bus.cpu_Databus_in, 16'h3333);
        bus.cpu_ReadMem = 0; bus.MemDataready = 0;
        tick;
        tick;
        chk("tie4.grant", 16'(bus.grant_dma), 16'h1);
        chk("tie4.addr",  bus.Addressbus,     16'h0400);
        bus.MemDataready = 1; bus.Databus_in = 16'h4444;
        tick;
        chk("tie4.data", bus.dma_rdata, 16'h4444);
        bus.dma_rd = 0; bus.MemDataready = 0;
        tick;

        // rd and wr together execute as a read
        bus.cpu_ReadMem = 1; bus.cpu_WriteMem = 1; bus.cpu_Addressbus = 16'h0ABC;
        tick;
        chk("rw.rd", 16'(bus.ReadMem),  16'h1);
        chk("rw.wr", 16'(bus.WriteMem), 16'h0);
        bus.MemDataready = 1; bus.Databus_in = 16'h6666;
        tick;
        chk("rw.data", bus.cpu_Databus_in, 16'h6666);
        bus.cpu_ReadMem = 0; bus.cpu_WriteMem = 0; bus.MemDataready = 0;
        tick;

        // Reset in the 2nd cycle of a CPU read, with MemDataready also high
        bus.cpu_ReadMem = 1; bus.cpu_Addressbus = 16'h0050;
        tick;
        tick;
        rst = 1; bus.MemDataready = 1; bus.Databus_in = 16'hDEAD;
        tick;
        chkQuiet("mrst");
        chk("mrst.addr",  bus.Addressbus,     16'h0000);
        chk("mrst.cpuRd", bus.cpu_Databus_in, 16'h0000);
        chk("mrst.grant", 16'(bus.grant_dma), 16'h0);
        rst = 0; bus.MemDataready = 0;
        bus.dma_rd = 1; bus.dma_addr = 16'h0600;
        tick;
        chk("mrst.tie",  16'(bus.grant_dma), 16'h0);
        chk("mrst.addr2", bus.Addressbus,    16'h0050);
        bus.MemDataready = 1; bus.Databus_in = 16'h0101;
        tick;
        bus.cpu_ReadMem = 0; bus.MemDataready = 0;
        tick;
        tick;
        bus.MemDataready = 1;
        tick;
        bus.dma_rd = 0; bus.MemDataready = 0;
        tick;

        // Timeout behaviour (MemDataready held low)
        bus.cpu_ReadMem = 1; bus.cpu_Addressbus = 16'h0070;
        tick;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 1; i < 4; i++) begin
            tick;
            chk("to.wait.rd",  16'(bus.ReadMem),       16'h1);
            chk("to.wait.rdy", 16'(bus.cpu_Dataready), 16'h0);
        end
        tick;
        chk("to.rdy",  16'(bus.cpu_Dataready), 16'h1);
        chk("to.err",  16'(bus.timeout_err),   16'h1);
        chk("to.data", bus.cpu_Databus_in,     16'hFFFF);
        chk("to.rd",   16'(bus.ReadMem),       16'h0);
        bus.cpu_ReadMem = 0;
        tick;
        chk("to.errOff", 16'(bus.timeout_err), 16'h0);
        // MemDataready in the deciding cycle wins
        bus.cpu_ReadMem = 1;
        tick;
        tick; tick; tick;
        bus.MemDataready = 1; bus.Databus_in = 16'h0C0C;
        tick;
        chk("toRace.rdy",  16'(bus.cpu_Dataready), 16'h1);
        chk("toRace.err",  16'(bus.timeout_err),   16'h0);
        chk("toRace.data", bus.cpu_Databus_in,     16'h0C0C);
        bus.cpu_ReadMem = 0; bus.MemDataready = 0;
        tick;
`else
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("noTo.rd",  16'(bus.ReadMem),       16'h1);
            chk("noTo.rdy", 16'(bus.cpu_Dataready), 16'h0);
            chk("noTo.err", 16'(bus.timeout_err),   16'h0);
        end
        bus.MemDataready = 1; bus.Databus_in = 16'h0C0C;
        tick;
        chk("noTo.end",  16'(bus.cpu_Dataready), 16'h1);
        chk("noTo.data", bus.cpu_Databus_in,     16'h0C0C);
        bus.cpu_ReadMem = 0; bus.MemDataready = 0;
        tick;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
